// File: rtl/uart_rx.sv
// ============================================================================
// uart_rx
// ----------------------------------------------------------------------------
// Oversampling serial receiver. It recovers start / data / parity / stop
// framing from rx_in and presents each received word in parallel, with a
// one-cycle data_valid pulse.
//
// Frame on the line: start(0), WIDTH data bits MSB first, even parity bit
// (only when UART_RX_PARITY_EN is defined), stop(1).
//
// Build option:
//   UART_RX_PARITY_EN  defined   : PARITY state present, frame is WIDTH+3 bits
//                      undefined : no parity bit on the line, frame is WIDTH+2
//                                  bits, parity_err is tied to 0
//
// Parameters:
//   WIDTH       data bits per frame
//   OVERSAMPLE  clk_baud ticks per bit period (even, >= 4)
//
// Ports:
//   clk_baud    in   clock for all state, OVERSAMPLE x bit rate
//   rst         in   asynchronous reset, ACTIVE-LOW
//   rx_in       in   serial line, idles high, asynchronous to clk_baud
//   data_out    out  last received word, held until the next frame completes
//   data_valid  out  one-cycle pulse: data_out / parity_err / frame_err valid
//   parity_err  out  (^data) != received parity bit, held with data_out
//   frame_err   out  stop bit sampled 0, held with data_out
//   rx_busy     out  high whenever the FSM is not in IDLE
//   dbg_state   out  current FSM state encoding (IDLE=0, START=1, DATA=2,
//                    PARITY=3, STOP=4, WAIT_IDLE=5)
//
// Handshake: there is no back-pressure. data_valid is high for exactly one
// clk_baud cycle per completed frame; the consumer must capture data_out and
// the error flags on that cycle or later (they hold until the next frame).
// ============================================================================
module uart_rx #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk_baud,
  input  logic             rst,
  input  logic             rx_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             rx_busy,
  output logic [2:0]       dbg_state
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic             rx_meta;
  logic             rx_s;
  state_t           state;
  logic [TW-1:0]    tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             ferr_q;

  // --------------------------------------------------------------------------
  // Next-state values
  // --------------------------------------------------------------------------
  state_t           state_n;
  logic [TW-1:0]    tick_n;
  logic [BW-1:0]    bit_n;
  logic [WIDTH-1:0] shift_n;
  logic [WIDTH-1:0] data_n;
  logic             valid_n;
  logic             ferr_n;

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;
  logic perr_q;
  logic par_bit_n;
  logic perr_n;
`endif

  // --------------------------------------------------------------------------
  // Sequential process: synchroniser, FSM state and datapath registers.
  // The synchroniser resets to 1 so a reset never looks like a start edge.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_baud or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx_in;
      rx_s      <= rx_meta;
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift_q   <= shift_n;
      data_q    <= data_n;
      valid_q   <= valid_n;
      ferr_q    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_bit_q <= par_bit_n;
      perr_q    <= perr_n;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Combinational process: next state and datapath updates.
  // tick_cnt free-runs 0..OVERSAMPLE-1 inside a frame. START samples at the
  // half-bit point; from then on every sample at TICK_LAST is a full bit
  // later, i.e. in the middle of each following bit.
  // --------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    tick_n    = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);
    bit_n     = bit_cnt;
    shift_n   = shift_q;
    data_n    = data_q;
    valid_n   = 1'b0;
    ferr_n    = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_bit_n = par_bit_q;
    perr_n    = perr_q;
`endif

    case (state)
      S_IDLE: begin
        tick_n = '0;
        if (!rx_s) begin
          state_n = S_START;
        end
      end

      S_START: begin
        if (tick_cnt == TICK_MID) begin
          if (rx_s) begin
            // Line back high at mid start bit: a glitch, not a frame.
            state_n = S_IDLE;
          end else begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (tick_cnt == TICK_LAST) begin
          // Shift left, new bit enters at the LSB; the first bit ends in MSB.
          shift_n = WIDTH'({shift_q, rx_s});
          if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick_cnt == TICK_LAST) begin
          par_bit_n = rx_s;
          state_n   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        // Leaving at mid-stop gives half a bit of slack to catch the next
        // start edge of a back-to-back frame.
        if (tick_cnt == TICK_LAST) begin
          data_n  = shift_q;
          ferr_n  = ~rx_s;
          valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_n  = (^shift_q) ^ par_bit_q;
`endif
          state_n = rx_s ? S_IDLE : S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        // Break or framing error: wait for the line to return high before
        // looking for another start bit.
        tick_n = '0;
        if (rx_s) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
        tick_n  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;
  assign rx_busy    = (state != S_IDLE);
  assign dbg_state  = state;

`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
